snake_move_ctrl: RTL and testbench



---
 rtl/snake_pkg.sv | 42 ++++
 rtl/snake_step_timer.sv | 50 +++++
 rtl/snake_move_ctrl.sv | 162 ++++++++++++++++
 tb/tb_snake_move_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game datapath: screen and play-frame geometry,
// direction and game-state encodings. Imported by the movement controller and the
// drawing stage so both agree on cell coordinates and encodings.
package snake_pkg;

  // Screen and play-frame geometry (pixels / grid cells).
  localparam int unsigned HOR_PIX      = 1024;
  localparam int unsigned VER_PIX      = 768;
  localparam int unsigned GRID_SIZE    = 16;
  localparam int unsigned FRAME_X_SIZE = 40;
  localparam int unsigned FRAME_Y_SIZE = 20;
  localparam int unsigned FRAME_WIDTH  = 1;

  // Inner playfield: top-left pixel of the first and last legal head cells.
  localparam int unsigned X_MIN = (HOR_PIX - FRAME_X_SIZE * GRID_SIZE) / 2 +
                                  FRAME_WIDTH * GRID_SIZE;
  localparam int unsigned X_MAX = X_MIN + (FRAME_X_SIZE - 2 * FRAME_WIDTH - 1) * GRID_SIZE;
  localparam int unsigned Y_MIN = (VER_PIX - FRAME_Y_SIZE * GRID_SIZE) / 2 +
                                  FRAME_WIDTH * GRID_SIZE;
  localparam int unsigned Y_MAX = Y_MIN + (FRAME_Y_SIZE - 2 * FRAME_WIDTH - 1) * GRID_SIZE;

  localparam int unsigned HOME_X = HOR_PIX / 2;
  localparam int unsigned HOME_Y = VER_PIX / 2;

  // Direction encoding: bit 1 selects the axis, bit 0 the sign.
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } state_e;

  // Reverse direction: same axis, opposite sign.
  function automatic logic [1:0] opposite_dir(logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/snake_step_timer.sv
// Frame-rate step divider for the snake head.
// Detects rising edges of vsync_in and counts them; every FRAMES_PER_STEP-th edge
// while enabled raises step_req for one cycle (combinationally, in the cycle the
// edge is first seen so the step lands on that same clock edge).
// Ports:
//   pclk, rst_n  clock, asynchronous active-low reset
//   vsync_in     vertical sync; each rising edge is one frame
//   enable       count frames (game running)
//   clear        force the frame counter to zero (has priority)
//   step_req     one-cycle step request
module snake_step_timer #(
  parameter int unsigned FRAMES_PER_STEP = 8
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic vsync_in,
  input  logic enable,
  input  logic clear,
  output logic step_req
);

  localparam logic [7:0] LastCnt = 8'(FRAMES_PER_STEP - 1);

  logic       vsync_q;
  logic       frame_pulse;
  logic [7:0] cnt_q, cnt_d;

  assign frame_pulse = vsync_in & ~vsync_q;
  assign step_req    = enable & frame_pulse & (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && frame_pulse) begin
      cnt_d = (cnt_q == LastCnt) ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      vsync_q <= vsync_in;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/snake_move_ctrl.sv
// Snake head movement controller: IDLE/RUN/OVER game FSM, button direction latch
// and head position datapath. The head steps one grid cell every FRAMES_PER_STEP
// vsync frames in the latched direction; leaving the playfield ends the game.
// Build option: define SNAKE_WRAP_EN to wrap the head to the opposite edge instead
// of ending the game on a wall.
// Ports:
//   pclk, rst_n            clock, asynchronous active-low reset
//   vsync_in               vertical sync from the timing chain
//   btn_up/down/left/right direction requests (level, synchronised)
//   btn_start              start/restart request (level, synchronised)
//   head_x, head_y         head cell top-left pixel
//   dir                    current direction (00 up, 01 down, 10 left, 11 right)
//   state                  game state (00 IDLE, 01 RUN, 10 OVER)
//   step_tick              one-cycle pulse per applied step
//   game_over              high while in OVER
module snake_move_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned FRAMES_PER_STEP = 8
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        vsync_in,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_start,
  output logic [10:0] head_x,
  output logic [10:0] head_y,
  output logic [1:0]  dir,
  output logic [1:0]  state,
  output logic        step_tick,
  output logic        game_over
);

  localparam logic [11:0] Grid  = 12'(GRID_SIZE);
  localparam logic [11:0] XMin  = 12'(X_MIN);
  localparam logic [11:0] XMax  = 12'(X_MAX);
  localparam logic [11:0] YMin  = 12'(Y_MIN);
  localparam logic [11:0] YMax  = 12'(Y_MAX);
  localparam logic [10:0] HomeX = 11'(HOME_X);
  localparam logic [10:0] HomeY = 11'(HOME_Y);

  state_e      state_q;
  logic [10:0] head_x_q, head_y_q;
  logic [1:0]  dir_q, pend_q, pend_d;
  logic        step_tick_q, game_over_q, start_q;
  logic        start_pulse, step_req;
  logic        req_valid;
  logic [1:0]  req_dir;
  logic [11:0] nx, ny;
  logic        step_ok;

  snake_step_timer #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_step_timer (
    .pclk    (pclk),
    .rst_n   (rst_n),
    .vsync_in(vsync_in),
    .enable  (state_q == ST_RUN),
    .clear   (state_q != ST_RUN),
    .step_req(step_req)
  );

  assign start_pulse = btn_start & ~start_q;

  // Fixed button priority: up > down > left > right.
  always_comb begin
    req_valid = 1'b1;
    req_dir   = DIR_UP;
    if (btn_up) begin
      req_dir = DIR_UP;
    end else if (btn_down) begin
      req_dir = DIR_DOWN;
    end else if (btn_left) begin
      req_dir = DIR_LEFT;
    end else if (btn_right) begin
      req_dir = DIR_RIGHT;
    end else begin
      req_valid = 1'b0;
    end
  end

  // A reversal onto the snake's own body is never accepted.
  assign pend_d = (req_valid && (req_dir != opposite_dir(dir_q))) ? req_dir : pend_q;

  // Candidate position for the pending direction, 12 bits wide so nothing wraps.
  always_comb begin
    nx = {1'b0, head_x_q};
    ny = {1'b0, head_y_q};
    unique case (pend_q)
      DIR_UP:    ny = ny - Grid;
      DIR_DOWN:  ny = ny + Grid;
      DIR_LEFT:  nx = nx - Grid;
      DIR_RIGHT: nx = nx + Grid;
    endcase
`ifdef SNAKE_WRAP_EN
    if (nx < XMin) nx = XMax;
    if (nx > XMax) nx = XMin;
    if (ny < YMin) ny = YMax;
    if (ny > YMax) ny = YMin;
`endif
    step_ok = (nx >= XMin) && (nx <= XMax) && (ny >= YMin) && (ny <= YMax);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      head_x_q    <= HomeX;
      head_y_q    <= HomeY;
      dir_q       <= DIR_RIGHT;
      pend_q      <= DIR_RIGHT;
      step_tick_q <= 1'b0;
      game_over_q <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      start_q     <= btn_start;
      step_tick_q <= 1'b0;
      pend_q      <= pend_d;
      case (state_q)
        ST_IDLE: begin
          head_x_q <= HomeX;
          head_y_q <= HomeY;
          if (start_pulse) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (step_req) begin
            dir_q <= pend_q;
            if (step_ok) begin
              head_x_q    <= nx[10:0];
              head_y_q    <= ny[10:0];
              step_tick_q <= 1'b1;
            end else begin
              state_q     <= ST_OVER;
              game_over_q <= 1'b1;
            end
          end
        end
        ST_OVER: begin
          if (start_pulse) begin
            state_q     <= ST_IDLE;
            game_over_q <= 1'b0;
            head_x_q    <= HomeX;
            head_y_q    <= HomeY;
            dir_q       <= DIR_RIGHT;
            pend_q      <= DIR_RIGHT;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign head_x    = head_x_q;
  assign head_y    = head_y_q;
  assign dir       = dir_q;
  assign state     = state_q;
  assign step_tick = step_tick_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Bench for snake_move_ctrl: directed scenarios plus a long randomized run, all
// compared against a cycle-level behavioural model of the game rules.
module tb_snake_move_ctrl;

  localparam int FPS = 8;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic        vsync_in, btn_up, btn_down, btn_left, btn_right, btn_start;
  logic [10:0] head_x, head_y;
  logic [1:0]  dir, state;
  logic        step_tick, game_over;

  snake_move_ctrl #(
    .FRAMES_PER_STEP(FPS)
  ) dut (
    .pclk     (pclk),
    .rst_n    (rst_n),
    .vsync_in (vsync_in),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .btn_start(btn_start),
    .head_x   (head_x),
    .head_y   (head_y),
    .dir      (dir),
    .state    (state),
    .step_tick(step_tick),
    .game_over(game_over)
  );

  always #5 pclk = ~pclk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  int tick_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: game rules with integer coordinates.
  int m_x, m_y, m_dir, m_pend, m_state, m_frames, m_tick;
  bit m_vs_prev, m_st_prev;
  int opp[4] = '{1, 0, 3, 2};

  always @(posedge pclk or negedge rst_n) begin : model_step
    bit frame, start;
    int req, nxt_pend, nx, ny;
    if (!rst_n) begin
      m_x = 512; m_y = 384; m_dir = 3; m_pend = 3; m_state = 0;
      m_frames = 0; m_tick = 0; m_vs_prev = 0; m_st_prev = 0;
    end else begin
      frame     = vsync_in && !m_vs_prev;
      start     = btn_start && !m_st_prev;
      m_vs_prev = vsync_in;
      m_st_prev = btn_start;
      req = btn_up ? 0 : btn_down ? 1 : btn_left ? 2 : btn_right ? 3 : -1;
      nxt_pend = (req >= 0 && req != opp[m_dir]) ? req : m_pend;
      m_tick = 0;
      case (m_state)
        0: begin
          m_frames = 0;
          if (start) m_state = 1;
        end
        1: begin
          if (frame) begin
            m_frames++;
            if (m_frames == FPS) begin
              m_frames = 0;
              m_dir = m_pend;
              nx = m_x + ((m_dir == 3) ? 16 : (m_dir == 2) ? -16 : 0);
              ny = m_y + ((m_dir == 1) ? 16 : (m_dir == 0) ? -16 : 0);
`ifdef SNAKE_WRAP_EN
              if (nx > 800) nx = 208;
              if (nx < 208) nx = 800;
              if (ny > 512) ny = 240;
              if (ny < 240) ny = 512;
`endif
              if (nx >= 208 && nx <= 800 && ny >= 240 && ny <= 512) begin
                m_x = nx; m_y = ny; m_tick = 1;
              end else begin
                m_state = 2;
              end
            end
          end
        end
        default: begin
          m_frames = 0;
          if (start) begin
            m_state = 0; m_x = 512; m_y = 384; m_dir = 3; nxt_pend = 3;
          end
        end
      endcase
      m_pend = nxt_pend;
    end
  end

  always @(negedge pclk) begin
    if (step_tick) tick_cnt++;
    if (rst_n && chk_en) begin
      check_eq("m_head_x", head_x, m_x);
      check_eq("m_head_y", head_y, m_y);
      check_eq("m_dir", dir, m_dir);
      check_eq("m_state", state, m_state);
      check_eq("m_step_tick", step_tick, m_tick);
      check_eq("m_game_over", game_over, (m_state == 2) ? 1 : 0);
    end
  end

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge pclk) vsync_in = 1'b1;
      repeat (3) @(negedge pclk);
      vsync_in = 1'b0;
      repeat (3) @(negedge pclk);
    end
  endtask

  task automatic pulse_start();
    @(negedge pclk) btn_start = 1'b1;
    @(negedge pclk) btn_start = 1'b0;
  endtask

  task automatic sync_reset();
    @(negedge pclk) rst_n = 1'b0;
    @(negedge pclk) rst_n = 1'b1;
  endtask

  initial begin : stim
    int t0, trans, vcnt;
    logic [1:0] prev;
    rst_n = 1'b0; vsync_in = 1'b0; btn_start = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    repeat (3) @(negedge pclk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge pclk);
    check_eq("rst_head_x", head_x, 512);
    check_eq("rst_head_y", head_y, 384);
    check_eq("rst_dir", dir, 3);
    check_eq("rst_state", state, 0);
    check_eq("rst_game_over", game_over, 0);

    // Basic stepping: two steps in 16 frames.
    pulse_start();
    check_eq("start_run", state, 1);
    t0 = tick_cnt;
    frames(16);
    check_eq("basic_ticks", tick_cnt - t0, 2);
    check_eq("basic_x", head_x, 544);
    check_eq("basic_y", head_y, 384);

    // Reverse request ignored while moving right.
    btn_left = 1'b1;
    frames(8);
    btn_left = 1'b0;
    check_eq("rev_x", head_x, 560);
    check_eq("rev_dir", dir, 3);

    // Up beats left.
    btn_up = 1'b1; btn_left = 1'b1;
    frames(8);
    btn_up = 1'b0; btn_left = 1'b0;
    check_eq("prio_y", head_y, 368);
    check_eq("prio_x", head_x, 560);
    check_eq("prio_dir", dir, 0);

    // Asynchronous reset mid-run, between clock edges.
    frames(3);
    @(negedge pclk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_head_x", head_x, 512);
    check_eq("arst_head_y", head_y, 384);
    check_eq("arst_dir", dir, 3);
    check_eq("arst_state", state, 0);
    check_eq("arst_step_tick", step_tick, 0);
    check_eq("arst_game_over", game_over, 0);
    @(negedge pclk) rst_n = 1'b1;

    // Held start gives exactly one transition.
    @(negedge pclk) btn_start = 1'b1;
    prev = state;
    trans = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge pclk);
      if (state != prev) trans++;
      prev = state;
    end
    btn_start = 1'b0;
    check_eq("hold_start_trans", trans, 1);
    check_eq("hold_start_state", state, 1);
    @(negedge pclk);
    pulse_start();
    check_eq("start_in_run", state, 1);

    // Run into the right wall.
    sync_reset();
    pulse_start();
    frames(18 * FPS);
    check_eq("wall_x18", head_x, 800);
    check_eq("wall_y18", head_y, 384);
    t0 = tick_cnt;
    frames(FPS);
`ifdef SNAKE_WRAP_EN
    check_eq("wrap_x", head_x, 208);
    check_eq("wrap_state", state, 1);
    check_eq("wrap_ticks", tick_cnt - t0, 1);
`else
    check_eq("over_x", head_x, 800);
    check_eq("over_state", state, 2);
    check_eq("over_game_over", game_over, 1);
    check_eq("over_ticks", tick_cnt - t0, 0);
    pulse_start();
    check_eq("restart_state", state, 0);
    check_eq("restart_x", head_x, 512);
    check_eq("restart_y", head_y, 384);
    check_eq("restart_dir", dir, 3);
`endif

    // Randomized play against the model.
    sync_reset();
    vcnt = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge pclk);
      btn_up    = ($urandom_range(0, 7) == 0);
      btn_down  = ($urandom_range(0, 7) == 0);
      btn_left  = ($urandom_range(0, 7) == 0);
      btn_right = ($urandom_range(0, 7) == 0);
      btn_start = ($urandom_range(0, 149) == 0);
      if (vcnt == 0) begin
        vsync_in = ~vsync_in;
        vcnt = $urandom_range(1, 4);
      end else begin
        vcnt--;
      end
    end
    @(negedge pclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
